// File: rtl/button_debounce.sv
// Debounces a raw push-button and classifies press, release and long-press events.
// Press and release are accepted DEBOUNCE_CYCLES+2 edges after the raw level changes; all outputs are registered.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 100000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic [HW-1:0]   r_hold;
  logic            r_done;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            r_long;
  logic            w_btn_s;

  // Synchronized level normalised so that 1 always means pressed.
  assign w_btn_s = r_sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= {2{ACTIVE_LOW}};
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_done    <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn_in};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_hold <= '0;
          r_done <= 1'b0;
          if (w_btn_s) r_state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_press <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Hold time accrues only while PRESSED; it saturates rather than wrapping.
          if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
          if (r_hold == HOLD_LAST && !r_done) begin
            r_long <= 1'b1;
            r_done <= 1'b1;
          end
          if (!w_btn_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_btn_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_level   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign btn_level        = r_level;
  assign press_pulse      = r_press;
  assign release_pulse    = r_release;
  assign long_press_pulse = r_long;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: an active-high and an active-low instance share clock and reset.
module tb_button_debounce;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int dut;
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_a, btn_b;
  logic lvl_a, press_a, rel_a, long_a;
  logic lvl_b, press_b, rel_b, long_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_a), .btn_level(lvl_a),
    .press_pulse(press_a), .release_pulse(rel_a), .long_press_pulse(long_a)
  );

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_b), .btn_level(lvl_b),
    .press_pulse(press_b), .release_pulse(rel_b), .long_press_pulse(long_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int kind, input int at);
    ev_t e;
    e.dut  = dut;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every observed strobe must match the head of the expected-event queue.
  task automatic handle(input int dut, input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("spurious_pulse_dut%0d_kind%0d", dut, kind), 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("pulse_identity", dut * 4 + kind, e.dut * 4 + e.kind);
      check($sformatf("pulse_cycle_dut%0d_kind%0d", dut, kind), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (press_a) handle(0, K_PRESS);
    if (rel_a)   handle(0, K_REL);
    if (long_a)  handle(0, K_LONG);
    if (press_b) handle(1, K_PRESS);
    if (rel_b)   handle(1, K_REL);
    if (long_b)  handle(1, K_LONG);
  end

  initial begin
    int p;
    int c;
    logic [4:0] pat;

    rst   = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b1;
    tick(3);
    check("rst_level_a",   lvl_a,   0);
    check("rst_press_a",   press_a, 0);
    check("rst_release_a", rel_a,   0);
    check("rst_long_a",    long_a,  0);
    check("rst_level_b",   lvl_b,   0);
    check("rst_press_b",   press_b, 0);
    rst = 1'b0;
    tick(3);

    // Clean press, long hold, then release.
    btn_a = 1'b1;
    p = cyc + 7;
    push(0, K_PRESS, p);
    push(0, K_LONG, p + 20);
    wait_until(p - 1);
    check("level_before_accept", lvl_a, 0);
    wait_until(p + 1);
    check("level_after_press", lvl_a, 1);
    wait_until(p + 40);
    btn_a = 1'b0;
    push(0, K_REL, cyc + 7);
    wait_until(cyc + 10);
    check("level_after_release", lvl_a, 0);

    // Bounce 1,0,1,1,0 then stable press.
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_a = pat[i];
      tick(1);
    end
    btn_a = 1'b1;
    p = cyc + 7;
    push(0, K_PRESS, p);
    wait_until(p + 3);
    btn_a = 1'b0;
    push(0, K_REL, cyc + 7);
    tick(10);

    // Two-cycle release glitch while pressed delays the long press by two cycles.
    btn_a = 1'b1;
    p = cyc + 7;
    push(0, K_PRESS, p);
    push(0, K_LONG, p + 22);
    wait_until(p + 5);
    btn_a = 1'b0;
    tick(2);
    btn_a = 1'b1;
    wait_until(p + 12);
    check("level_through_glitch", lvl_a, 1);
    wait_until(p + 30);
    btn_a = 1'b0;
    push(0, K_REL, cyc + 7);
    tick(10);

    // Reset during PRESS_WAIT with counter at 2; button stays held.
    btn_a = 1'b1;
    c = cyc;
    wait_until(c + 5);
    rst = 1'b1;
    tick(1);
    check("midwait_rst_level", lvl_a, 0);
    check("midwait_rst_press", press_a, 0);
    rst = 1'b0;
    p = cyc + 7;
    push(0, K_PRESS, p);

    // Reset on the cycle the long press would fire; it is dropped and the held press re-accepted.
    wait_until(p + 19);
    rst = 1'b1;
    tick(1);
    check("midhold_rst_level", lvl_a, 0);
    check("midhold_rst_long", long_a, 0);
    rst = 1'b0;
    p = cyc + 7;
    push(0, K_PRESS, p);
    wait_until(p + 3);
    btn_a = 1'b0;
    push(0, K_REL, cyc + 7);
    tick(10);

    // Active-low instance: idle high produced nothing so far; now press by driving low.
    btn_b = 1'b0;
    p = cyc + 7;
    push(1, K_PRESS, p);
    wait_until(p + 1);
    check("al_level_pressed", lvl_b, 1);
    wait_until(p + 3);
    btn_b = 1'b1;
    push(1, K_REL, cyc + 7);
    tick(10);
    check("al_level_released", lvl_b, 0);

    tick(5);
    check("expected_events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Purpose: debounce and edge-classify a raw board push-button. Its clean pulses drive the LED blink/counter stage.

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, int, default 100000: consecutive stable synchronized samples needed to accept a level change; legal range >= 1.
REQ-002 Parameter LONG_PRESS_CYCLES, int, default 50000000: hold duration after press acceptance that qualifies a long press; must exceed DEBOUNCE_CYCLES.
REQ-003 Parameter ACTIVE_LOW, bit, default 0: 1 means btn_in low = pressed.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 btn_in  input  1  raw asynchronous button level, may bounce.
REQ-007 btn_level  output  1  debounced pressed level, 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 long_press_pulse  output  1  one-cycle strobe when a press has been held LONG_PRESS_CYCLES.

Function
REQ-011 btn_in shall pass through a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1, giving btn_s (1 = pressed).
REQ-012 FSM states shall be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with one debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 IDLE shall go to PRESS_WAIT with counter = 0 when btn_s = 1; otherwise it stays in IDLE.
REQ-014 PRESS_WAIT:
- btn_s = 0: go to IDLE, clear counter, no pulse.
- btn_s = 1 and counter = DEBOUNCE_CYCLES-1: go to PRESSED, register press_pulse = 1 and btn_level = 1.
- otherwise: counter + 1.
REQ-015 PRESSED shall go to RELEASE_WAIT with counter = 0 when btn_s = 0.
REQ-016 RELEASE_WAIT is the mirror of PRESS_WAIT:
- btn_s = 1: return to PRESSED.
- btn_s = 0 and counter = DEBOUNCE_CYCLES-1: go to IDLE, register release_pulse = 1 and btn_level = 0.
REQ-017 Latency: press_pulse shall be high in the cycle after posedge number DEBOUNCE_CYCLES+2, where edge 0 is the first edge sampling btn_in pressed and btn_in stays pressed throughout. Release latency shall be identical.
REQ-018 Hold counter, width $clog2(LONG_PRESS_CYCLES+1):
- cleared on the transition into PRESSED from PRESS_WAIT;
- increments each cycle in PRESSED;
- frozen in RELEASE_WAIT;
- cleared in IDLE.
REQ-019 long_press_pulse shall assert for one cycle when the hold counter = LONG_PRESS_CYCLES-1 in PRESSED, i.e. LONG_PRESS_CYCLES cycles after press_pulse rises (RELEASE_WAIT time excluded).
REQ-020 long_press_pulse shall fire at most once per accepted press. A done flag suppresses further pulses and is cleared in IDLE.
REQ-021 Exactly one accepted release shall follow each accepted press. press_pulse and release_pulse shall never be high in the same cycle.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES samples shall produce no pulse and no btn_level change. A failed wait state shall always return to its origin state.
REQ-023 All outputs shall be registered, with no combinational path from btn_in.
REQ-024 Counters shall never wrap: each wait or hold ends at its terminal count, and the hold counter saturates.

Reset
REQ-025 While rst = 1:
- state = IDLE; both counters = 0; done flag = 0;
- all outputs = 0;
- synchronizer flops = released level (1 if ACTIVE_LOW, else 0).
REQ-026 rst shall take priority over every transition, including mid-PRESS_WAIT and mid-hold. A pending pulse shall be dropped.
REQ-027 If the button is held across reset deassertion, a normal press shall be accepted per REQ-017, counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=0)
REQ-028 Clean press at edge 0, held -> press_pulse high exactly one cycle after edge 6; btn_level = 1 from then on.
REQ-029 Bounce pattern 1,0,1,1,0 then stable 1 -> no pulse during bounce; one press_pulse 6 edges after stable 1 begins.
REQ-030 Hold 40 cycles after press_pulse -> one long_press_pulse 20 cycles after press_pulse, none afterwards; release -> one release_pulse 6 edges later.
REQ-031 While PRESSED, a 2-cycle release glitch -> no release_pulse; hold counter pauses, so long_press_pulse is delayed by the glitch cycles.
REQ-032 rst asserted for 1 cycle during PRESS_WAIT (counter = 2) -> all outputs 0; press_pulse 6 edges after the first post-reset edge if btn_in is still held.
REQ-033 ACTIVE_LOW=1, btn_in idle high -> no pulses after reset; btn_in low -> press_pulse per REQ-017.
